// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-port memory with fixed read latency.
// Latency: read ready at N+MEM_LAT+2, write ready at N+2 (N = cycle the request is first seen idle).
// Backpressure: one access in flight; requests are only looked at in IDLE, so callers hold until ready.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   i_addr, i_oe                instruction fetch request
//   i_din, i_ready              instruction read data and one-cycle completion pulse
//   d_addr, d_oe, d_dout, d_we  data read/write request (d_we: [1]=high byte, [0]=low byte)
//   d_din, d_ready              data read data and one-cycle completion pulse
//   m_addr, m_oe, m_we, m_dout  memory command, driven only during the ISSUE cycle
//   m_din                       memory read data, valid MEM_LAT cycles after the m_oe cycle
module mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic        i_oe,
  output logic [15:0] i_din,
  output logic        i_ready,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  input  logic [15:0] d_dout,
  input  logic [1:0]  d_we,
  output logic [15:0] d_din,
  output logic        d_ready,
  output logic [15:0] m_addr,
  output logic        m_oe,
  output logic [1:0]  m_we,
  output logic [15:0] m_dout,
  input  logic [15:0] m_din
);

  localparam int              SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [2:0]      WAIT_LAST  = 3'(MEM_LAT - 1);
  localparam logic            OWN_I      = 1'b0;
  localparam logic            OWN_D      = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          owner;
  logic          is_wr;
  logic [2:0]    wait_cnt;
  logic [SW-1:0] starve_cnt;

  logic          i_req;
  logic          d_req;
  logic          i_win;
  logic          grant;
  logic          wait_done;

  // Arbitration and next-state decode. D normally wins; once I has lost
  // STARVE_MAX arbitrations in a row it is guaranteed the next grant.
  always_comb begin
    i_req     = i_oe;
    d_req     = d_oe | (|d_we);
    i_win     = i_req && (!d_req || (starve_cnt >= STARVE_LIM));
    grant     = (state == IDLE) && (i_req || d_req);
    wait_done = (wait_cnt == WAIT_LAST);
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = is_wr ? RESP : WAIT;
      WAIT:    if (wait_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath. m_addr/m_dout double as the latched request, so the memory
  // command is registered at grant and visible for the whole ISSUE cycle.
  // Ready pulses are registered on entry to RESP, so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_I;
      is_wr      <= 1'b0;
      wait_cnt   <= 3'd0;
      starve_cnt <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      i_din      <= 16'h0000;
      d_din      <= 16'h0000;
      m_addr     <= 16'h0000;
      m_oe       <= 1'b0;
      m_we       <= 2'b00;
      m_dout     <= 16'h0000;
    end else begin
      m_oe    <= 1'b0;
      m_we    <= 2'b00;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner  <= i_win ? OWN_I : OWN_D;
            m_addr <= i_win ? i_addr : d_addr;
            // Any byte enable makes it a write; d_oe is then ignored.
            if (!i_win && (|d_we)) begin
              is_wr  <= 1'b1;
              m_we   <= d_we;
              m_dout <= d_dout;
            end else begin
              is_wr  <= 1'b0;
              m_oe   <= 1'b1;
            end
            if (i_win)
              starve_cnt <= '0;
            else if (i_req && (starve_cnt < STARVE_LIM))
              starve_cnt <= starve_cnt + SW'(1);
          end
        end
        ISSUE: begin
          wait_cnt <= 3'd0;
          // Only the D port can write, so a write always completes on D.
          if (is_wr) d_ready <= 1'b1;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 3'd1;
          if (wait_done) begin
            if (owner == OWN_I) begin
              i_din   <= m_din;
              i_ready <= 1'b1;
            end else begin
              d_din   <= m_din;
              d_ready <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic,
// every cycle compared against a transaction-level reference model.
// The model schedules each grant by its completion latency; it has no notion of FSM states.
module tb_mem_arbiter;

  localparam int MEM_LAT    = 1;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr, d_addr, d_dout, m_din;
  logic        i_oe, d_oe;
  logic [1:0]  d_we;
  logic [15:0] i_din, d_din, m_addr, m_dout;
  logic        i_ready, d_ready, m_oe;
  logic [1:0]  m_we;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_oe(i_oe), .i_din(i_din), .i_ready(i_ready),
    .d_addr(d_addr), .d_oe(d_oe), .d_dout(d_dout), .d_we(d_we),
    .d_din(d_din), .d_ready(d_ready),
    .m_addr(m_addr), .m_oe(m_oe), .m_we(m_we), .m_dout(m_dout), .m_din(m_din)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Memory contents: a fixed pattern until written. env_mem is what the DUT's
  // memory holds; ref_mem is the model's own view, updated from its own grants.
  logic [15:0] env_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] rd_env(input logic [15:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] rd_ref(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] we);
    return {we[1] ? nw[15:8] : old[15:8], we[0] ? nw[7:0] : old[7:0]};
  endfunction

  // Memory read-return pipeline.
  int          ret_cyc = -1;
  logic [15:0] ret_dat;

  // Reference model state.
  bit          model_on = 0;
  bit          busy     = 0;
  bit          mo_d, mo_wr;
  logic [15:0] mo_addr, mo_dat, mo_rdat;
  logic [1:0]  mo_we;
  int          mo_issue, mo_ready;
  int          starve   = 0;
  logic [15:0] e_m_addr, e_m_dout, e_i_din, e_d_din;

  // Observations for directed checks.
  int          n_i_rdy = 0, n_d_rdy = 0, n_moe = 0;
  int          last_i_rdy = -1, last_d_rdy = -1, last_moe = -1, last_mwe = -1;
  logic [1:0]  last_mwe_val;
  bit          rdy_seq [$];

  task automatic step(input bit r, input bit io, input logic [15:0] ia, input bit dox,
                      input logic [1:0] dwe, input logic [15:0] da, input logic [15:0] dd);
    bit e_moe, e_ir, e_dr, dreq, iwin;
    logic [1:0] e_mwe;
    @(posedge clk);
    #1;
    cyc++;
    rst = r; i_oe = io; i_addr = ia; d_oe = dox; d_we = dwe; d_addr = da; d_dout = dd;
    m_din = (cyc == ret_cyc) ? ret_dat : 16'($urandom);
    @(negedge clk);

    if (model_on) begin
      if (busy && cyc == mo_issue) begin
        e_m_addr = mo_addr;
        if (mo_wr) e_m_dout = mo_dat;
      end
      if (busy && cyc == mo_ready && !mo_wr) begin
        if (mo_d) e_d_din = mo_rdat;
        else      e_i_din = mo_rdat;
      end
      e_moe = busy && cyc == mo_issue && !mo_wr;
      e_mwe = (busy && cyc == mo_issue && mo_wr) ? mo_we : 2'b00;
      e_ir  = busy && cyc == mo_ready && !mo_d;
      e_dr  = busy && cyc == mo_ready && mo_d;
      check("m_oe",    32'(m_oe),    32'(e_moe));
      check("m_we",    32'(m_we),    32'(e_mwe));
      check("m_addr",  32'(m_addr),  32'(e_m_addr));
      check("m_dout",  32'(m_dout),  32'(e_m_dout));
      check("i_ready", 32'(i_ready), 32'(e_ir));
      check("d_ready", 32'(d_ready), 32'(e_dr));
      check("i_din",   32'(i_din),   32'(e_i_din));
      check("d_din",   32'(d_din),   32'(e_d_din));
      check("starve",  32'(dut.starve_cnt), 32'(starve));
    end

    if (i_ready === 1'b1) begin n_i_rdy++; last_i_rdy = cyc; rdy_seq.push_back(1'b1); end
    if (d_ready === 1'b1) begin n_d_rdy++; last_d_rdy = cyc; rdy_seq.push_back(1'b0); end
    if (m_oe === 1'b1) begin
      n_moe++; last_moe = cyc;
      ret_cyc = cyc + MEM_LAT;
      ret_dat = rd_env(m_addr);
    end
    if (m_we !== 2'b00 && !$isunknown(m_we)) begin
      last_mwe = cyc; last_mwe_val = m_we;
      env_mem[m_addr] = merge(rd_env(m_addr), m_dout, m_we);
    end

    if (r) begin
      busy = 0; starve = 0; model_on = 1;
      e_m_addr = 16'h0; e_m_dout = 16'h0; e_i_din = 16'h0; e_d_din = 16'h0;
    end else if (model_on) begin
      if (busy) begin
        if (cyc == mo_ready) busy = 0;
      end else if (io || dox || dwe != 2'b00) begin
        dreq = dox || dwe != 2'b00;
        iwin = io && (!dreq || starve >= STARVE_MAX);
        if (iwin) starve = 0;
        else if (io && starve < STARVE_MAX) starve++;
        busy     = 1;
        mo_d     = !iwin;
        mo_addr  = iwin ? ia : da;
        mo_wr    = !iwin && dwe != 2'b00;
        mo_we    = dwe;
        mo_dat   = dd;
        mo_issue = cyc + 1;
        mo_ready = mo_wr ? cyc + 2 : cyc + MEM_LAT + 2;
        if (mo_wr) ref_mem[mo_addr] = merge(rd_ref(mo_addr), dd, dwe);
        else       mo_rdat = rd_ref(mo_addr);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 16'h0, 0, 2'b00, 16'h0, 16'h0);
  endtask

  initial begin
    int n0, cnt0, moe0, pos1, pos2;
    rst = 1'b1; i_oe = 0; d_oe = 0; d_we = 0; i_addr = 0; d_addr = 0; d_dout = 0; m_din = 0;
    env_mem[16'h0010] = 16'hA5A5;
    ref_mem[16'h0010] = 16'hA5A5;

    step(1, 0, 16'h0, 0, 2'b00, 16'h0, 16'h0);
    step(1, 0, 16'h0, 0, 2'b00, 16'h0, 16'h0);
    idle(2);

    // I read of 0x0010.
    n0 = cyc + 1; cnt0 = n_i_rdy;
    step(0, 1, 16'h0010, 0, 2'b00, 16'h0, 16'h0);
    idle(5);
    check("s1_moe_cyc", 32'(last_moe), 32'(n0 + 1));
    check("s1_rdy_cyc", 32'(last_i_rdy), 32'(n0 + 3));
    check("s1_rdy_cnt", 32'(n_i_rdy - cnt0), 32'd1);
    check("s1_i_din", 32'(i_din), 32'hA5A5);

    // Simultaneous I read and D write: D first, then I.
    n0 = cyc + 1; cnt0 = n_i_rdy;
    step(0, 1, 16'h0010, 0, 2'b11, 16'h0200, 16'h1234);
    for (int k = 0; k < 3; k++) step(0, 1, 16'h0010, 0, 2'b00, 16'h0, 16'h0);
    idle(5);
    check("s2_mwe_cyc", 32'(last_mwe), 32'(n0 + 1));
    check("s2_mwe_val", 32'(last_mwe_val), 32'h3);
    check("s2_d_rdy_cyc", 32'(last_d_rdy), 32'(n0 + 2));
    check("s2_i_rdy_cnt", 32'(n_i_rdy - cnt0), 32'd1);

    // Both ports request continuously: I wins every fifth arbitration.
    rdy_seq.delete();
    for (int k = 0; k < 50; k++) step(0, 1, 16'h0010, 1, 2'b00, 16'h0004, 16'h0);
    idle(6);
    pos1 = -1; pos2 = -1;
    for (int k = 0; k < rdy_seq.size(); k++) begin
      if (rdy_seq[k]) begin
        if (pos1 < 0) pos1 = k;
        else if (pos2 < 0) pos2 = k;
      end
    end
    check("s3_first_i", 32'(pos1), 32'd4);
    check("s3_second_i", 32'(pos2), 32'd9);

    // d_oe with d_we=01 is a low-byte write, not a read.
    moe0 = n_moe; n0 = cyc + 1;
    step(0, 0, 16'h0, 1, 2'b01, 16'h0200, 16'hBEEF);
    idle(4);
    check("s4_mwe_val", 32'(last_mwe_val), 32'h1);
    check("s4_mwe_cyc", 32'(last_mwe), 32'(n0 + 1));
    check("s4_no_moe", 32'(n_moe - moe0), 32'd0);
    check("s4_mem", 32'(rd_ref(16'h0200)), 32'h12EF);

    // Reset during WAIT aborts the read.
    cnt0 = n_i_rdy; n0 = cyc + 1;
    step(0, 1, 16'h0010, 0, 2'b00, 16'h0, 16'h0);
    step(0, 0, 16'h0, 0, 2'b00, 16'h0, 16'h0);
    step(1, 0, 16'h0, 0, 2'b00, 16'h0, 16'h0);
    step(0, 0, 16'h0, 0, 2'b00, 16'h0, 16'h0);
    check("s5_state", 32'(dut.state), 32'd0);
    idle(4);
    check("s5_no_rdy", 32'(n_i_rdy - cnt0), 32'd0);

    // d_addr changes while the read is in flight.
    step(0, 0, 16'h0, 1, 2'b00, 16'h0020, 16'h0);
    for (int k = 0; k < 4; k++) step(0, 0, 16'h0, 0, 2'b00, 16'h0030 + 16'(k), 16'h0);
    idle(2);
    check("s6_d_din", 32'(d_din), 32'(init_val(16'h0020)));

    // Random traffic with occasional reset.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 199) == 0,
           1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)),
           $urandom_range(0, 3) == 0,
           ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
           16'($urandom_range(0, 31)), 16'($urandom));
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
